// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM boot loader: loader state
// encoding, instruction bus widths and the length header width.
package inst_rom_loader_pkg;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W      = 32;
  localparam int HDR_W           = 16;
  localparam int LD_BYTE_W       = 8;

  typedef enum logic [1:0] {
    HDR_HI = 2'd0,
    HDR_LO = 2'd1,
    DATA   = 2'd2,
    DONE   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/inst_rom_array.sv
// Instruction word store: one synchronous write port for the loader and one
// combinational read port for the fetch path. Contents are never reset.
module inst_rom_array
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [INST_BUS_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [INST_BUS_W-1:0] rdata_o
);

  logic [INST_BUS_W-1:0] mem [2**ADDR_W];

  // Loader write port, committed on the clock edge of the completing byte.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM responder with a byte-serial boot loader. A 16-bit
// big-endian word count header is followed by big-endian 32-bit words; the
// core is held in reset until the whole image has been received.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rom_ce_i,
  input  logic [INST_ADDR_BUS_W-1:0] rom_addr_i,
  output logic [INST_BUS_W-1:0]      rom_data_o,
  input  logic                       ld_valid_i,
  input  logic [LD_BYTE_W-1:0]       ld_byte_i,
  output logic                       ld_ready_o,
  input  logic                       reload_i,
  output logic                       core_rst_o,
  output logic                       load_done_o,
  output logic [HDR_W-1:0]           words_loaded_o
);

  ld_state_e         state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [HDR_W-1:0]  cnt_q, cnt_d;
  logic [HDR_W-1:0]  words_q, words_d;
  logic [23:0]       asm_q, asm_d;
  logic              core_rst_q, core_rst_d;
  logic              load_done_q, load_done_d;

  logic                  accept;
  logic                  in_range;
  logic                  we;
  logic [ADDR_W-1:0]     waddr;
  logic [INST_BUS_W-1:0] wdata;
  logic [ADDR_W-1:0]     raddr;
  logic [INST_BUS_W-1:0] rdata;
  logic                  addr_hit;
  logic                  unused_addr_lsb;

  assign accept   = ld_valid_i & ld_ready_o;
  // Words past the end of the array are counted but dropped, never wrapped.
  assign in_range = int'(words_q) < (1 << ADDR_W);
  assign waddr    = words_q[ADDR_W-1:0];
  assign wdata    = {asm_q, ld_byte_i};

  // Next-state logic for the loader FSM and the big-endian byte assembler.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    words_d     = words_q;
    asm_d       = asm_q;
    we          = 1'b0;
    case (state_q)
      HDR_HI: begin
        if (accept) begin
          cnt_d   = {ld_byte_i, cnt_q[7:0]};
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          cnt_d = {cnt_q[15:8], ld_byte_i};
          if (cnt_d == '0) begin
            state_d = DONE;
          end else begin
            words_d = '0;
            lane_d  = 2'd0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          lane_d = 2'(lane_q + 2'd1);
          asm_d  = {asm_q[15:0], ld_byte_i};
          if (lane_q == 2'd3) begin
            we      = in_range;
            words_d = 16'(words_q + 16'd1);
            if (words_d == cnt_q) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (reload_i) begin
          state_d = HDR_HI;
        end
      end
      default: state_d = HDR_HI;
    endcase
    core_rst_d  = (state_d != DONE);
    load_done_d = (state_d == DONE);
  end

  // Control state: FSM, lane, header count, word counter and core control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HDR_HI;
      lane_q      <= 2'd0;
      cnt_q       <= '0;
      words_q     <= '0;
      core_rst_q  <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      core_rst_q  <= core_rst_d;
      load_done_q <= load_done_d;
    end
  end

  // Partial word bytes; stale contents are shifted out before any use.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  inst_rom_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Byte address to word index; the two byte-offset bits are ignored.
  assign raddr           = rom_addr_i[ADDR_W+1:2];
  assign unused_addr_lsb = ^rom_addr_i[1:0];
  assign addr_hit        = (rom_addr_i[INST_ADDR_BUS_W-1:ADDR_W+2] == '0);
  assign rom_data_o      = (rom_ce_i && (state_q == DONE) && addr_hit) ? rdata : '0;

  assign ld_ready_o      = (state_q != DONE);
  assign core_rst_o      = core_rst_q;
  assign load_done_o     = load_done_q;
  assign words_loaded_o  = words_q;

endmodule
